conv_nc_fx: RTL and testbench

CONV_NC_FX -- requirements
Module: conv_nc_fx

---
 rtl/conv_nc_fx.sv | 250 +++++++++++++++++++++++++
 tb/tb_conv_nc_fx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_nc_fx.sv
// Event-driven convolution core with spiking neurons: weight/bias store, membrane accumulation
// with read-modify-write forwarding, and a LIF/IF activation sweep with a back-pressured spike stream.
module conv_nc_fx #(
    parameter int OC_PER_CORE = 2,
    parameter int IN_CHANNELS = 2,
    parameter int KERNEL_SIZE = 3,
    parameter int OUT_W       = 4,
    parameter int DW          = 16,
    parameter int WW          = 8,
    parameter int THRESH      = 64,
    parameter int LEAK_SHIFT  = 3,
    parameter int NEURON_TYPE = 0,
    parameter int RESET_MODE  = 0,
    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE,
    localparam int ROW_W = IN_CHANNELS * KK + 1,
    localparam int NW    = OC_PER_CORE * ROW_W,
    localparam int PLANE = OUT_W * OUT_W,
    localparam int DEPTH = OC_PER_CORE * PLANE,
    localparam int WA    = (NW > 1) ? $clog2(NW) : 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCW   = $clog2(OC_PER_CORE + 1),
    localparam int ICW   = $clog2(IN_CHANNELS + 1),
    localparam int KW    = $clog2(KK + 1),
    localparam int XW    = $clog2(OUT_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wt_we,
    input  logic [WA-1:0]        wt_addr,
    input  logic signed [WW-1:0] wt_wdata,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [OCW-1:0]       ev_oc,
    input  logic [ICW-1:0]       ev_ic,
    input  logic [KW-1:0]        ev_kidx,
    input  logic [XW-1:0]        ev_row,
    input  logic [XW-1:0]        ev_col,
    input  logic                 act_start,
    input  logic                 last_ts,
    output logic                 act_busy,
    output logic                 act_done,
    output logic                 spk_valid,
    input  logic                 spk_ready,
    output logic [AW-1:0]        spk_addr,
    output logic                 wt_err,
    output logic [31:0]          spk_cnt
);

    localparam int DW1 = DW + 1;
    localparam logic signed [DW:0]   VMAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0]   VMIN = -VMAX;
    localparam logic signed [DW-1:0] THR  = DW'(THRESH);
    localparam logic [AW:0]          PTR_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]          PTR_END  = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_ACCUM, S_DRAIN, S_ACTIV, S_DONE} state_t;

    function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] x);
        if (x > VMAX)      return VMAX[DW-1:0];
        else if (x < VMIN) return VMIN[DW-1:0];
        else               return x[DW-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [AW:0]           ptr_q, ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [AW-1:0]         s1_addr_q, s1_addr_d;
    logic signed [WW-1:0]  s1_w_q, s1_w_d;
    logic                  lw_valid_q, lw_valid_d;
    logic [AW-1:0]         lw_addr_q, lw_addr_d;
    logic signed [DW-1:0]  lw_data_q, lw_data_d;
    logic                  spk_valid_q, spk_valid_d;
    logic [AW-1:0]         spk_addr_q, spk_addr_d;
    logic [31:0]           spk_cnt_q, spk_cnt_d;
    logic                  wt_err_q, wt_err_d;

    logic signed [DW-1:0]  mem_q [DEPTH];
    logic signed [WW-1:0]  wt_mem_q [NW];
    logic signed [DW-1:0]  rd_data_q;

    logic                  mem_we, rd_en, wt_wr;
    logic [AW-1:0]         mem_waddr, rd_addr;
    logic signed [DW-1:0]  mem_wdata;
    logic                  ev_in_range, spk_hold;
    logic [AW-1:0]         ev_maddr, act_addr;
    logic [WA-1:0]         ev_widx, bias_idx;
    logic signed [DW-1:0]  acc_base, acc_val;
    logic signed [DW-1:0]  act_v, act_vp, act_wb;
    logic                  act_fire;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        s1_valid_d  = 1'b0;
        s1_addr_d   = s1_addr_q;
        s1_w_d      = s1_w_q;
        lw_valid_d  = 1'b0;
        lw_addr_d   = lw_addr_q;
        lw_data_d   = lw_data_q;
        spk_valid_d = spk_valid_q;
        spk_addr_d  = spk_addr_q;
        spk_cnt_d   = spk_cnt_q;
        wt_err_d    = wt_we && (state_q != S_IDLE);
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        wt_wr       = 1'b0;
        ev_ready    = 1'b0;
        act_busy    = 1'b0;
        act_done    = 1'b0;

        ev_in_range = (int'(ev_oc) < OC_PER_CORE) && (int'(ev_ic) < IN_CHANNELS) &&
                      (int'(ev_kidx) < KK) && (int'(ev_row) < OUT_W) && (int'(ev_col) < OUT_W);
        ev_maddr    = AW'(int'(ev_oc) * PLANE + int'(ev_row) * OUT_W + int'(ev_col));
        ev_widx     = WA'(int'(ev_oc) * ROW_W + int'(ev_ic) * KK + int'(ev_kidx));

        // A read issued in the same cycle as a write to the same word returns the old value,
        // so the previous cycle's write result is forwarded into the adder.
        acc_base = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : rd_data_q;
        acc_val  = sat(DW1'(acc_base) + DW1'(s1_w_q));
        if (s1_valid_q) begin
            mem_we     = 1'b1;
            mem_waddr  = s1_addr_q;
            mem_wdata  = acc_val;
            lw_valid_d = 1'b1;
            lw_addr_d  = s1_addr_q;
            lw_data_d  = acc_val;
        end

        act_addr = ptr_q[AW-1:0];
        bias_idx = WA'((int'(act_addr) / PLANE) * ROW_W + IN_CHANNELS * KK);
        act_v    = sat(DW1'(rd_data_q) + DW1'(wt_mem_q[bias_idx]));
        act_fire = int'(act_v) > THRESH;
        act_vp   = act_fire ? ((RESET_MODE == 0) ? act_v - THR : '0) : act_v;
        act_wb   = (NEURON_TYPE == 0) ? act_vp - (act_vp >>> LEAK_SHIFT) : act_vp;

        spk_hold = spk_valid_q && !spk_ready;
        if (spk_valid_q && spk_ready) spk_valid_d = 1'b0;

        case (state_q)
            S_CLR: begin
                mem_we    = 1'b1;
                mem_waddr = act_addr;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE, S_ACCUM: begin
                if (state_q == S_IDLE && wt_we && (int'(wt_addr) < NW)) wt_wr = 1'b1;
                if (act_start) begin
                    state_d = S_DRAIN;
                end else begin
                    ev_ready = 1'b1;
                    if (ev_valid) begin
                        state_d = S_ACCUM;
                        if (ev_in_range) begin
                            s1_valid_d = 1'b1;
                            s1_addr_d  = ev_maddr;
                            s1_w_d     = wt_mem_q[ev_widx];
                            rd_en      = 1'b1;
                            rd_addr    = ev_maddr;
                        end
                    end else if (state_q == S_ACCUM && !s1_valid_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = S_ACTIV;
                    ptr_d   = '0;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end
            end
            S_ACTIV: begin
                act_busy = 1'b1;
                // ptr == DEPTH is a flush slot: the sweep is over but the last spike may be unacknowledged.
                if (ptr_q == PTR_END) begin
                    if (!spk_hold) state_d = S_DONE;
                end else if (!spk_hold) begin
                    mem_we    = 1'b1;
                    mem_waddr = act_addr;
                    mem_wdata = last_ts ? '0 : act_wb;
                    if (act_fire) begin
                        spk_valid_d = 1'b1;
                        spk_addr_d  = act_addr;
                        spk_cnt_d   = spk_cnt_q + 32'd1;
                    end
                    ptr_d   = ptr_q + 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = AW'(ptr_q + 1'b1);
                end
            end
            S_DONE: begin
                act_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLR;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_w_q      <= '0;
            lw_valid_q  <= 1'b0;
            lw_addr_q   <= '0;
            lw_data_q   <= '0;
            spk_valid_q <= 1'b0;
            spk_addr_q  <= '0;
            spk_cnt_q   <= '0;
            wt_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_w_q      <= s1_w_d;
            lw_valid_q  <= lw_valid_d;
            lw_addr_q   <= lw_addr_d;
            lw_data_q   <= lw_data_d;
            spk_valid_q <= spk_valid_d;
            spk_addr_q  <= spk_addr_d;
            spk_cnt_q   <= spk_cnt_d;
            wt_err_q    <= wt_err_d;
        end
    end

    // Storage arrays carry no reset: membranes are cleared by the CLR sweep, weights survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (rd_en)  rd_data_q <= mem_q[rd_addr];
        if (wt_wr)  wt_mem_q[wt_addr] <= wt_wdata;
    end

    assign spk_valid = spk_valid_q;
    assign spk_addr  = spk_addr_q;
    assign spk_cnt   = spk_cnt_q;
    assign wt_err    = wt_err_q;

endmodule

// File: tb/tb_conv_nc_fx.sv
// Scoreboard bench for conv_nc_fx: a behavioural membrane/weight model predicts spikes and memory contents.
module tb_conv_nc_fx;
    localparam int DEPTH = 32;
    localparam int NW    = 38;
    localparam int THR   = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wt_we = 1'b0;
    logic [5:0]        wt_addr = '0;
    logic signed [7:0] wt_wdata = '0;
    logic              ev_valid = 1'b0;
    logic              ev_ready;
    logic [1:0]        ev_oc = '0;
    logic [1:0]        ev_ic = '0;
    logic [3:0]        ev_kidx = '0;
    logic [2:0]        ev_row = '0;
    logic [2:0]        ev_col = '0;
    logic              act_start = 1'b0;
    logic              last_ts = 1'b0;
    logic              act_busy, act_done;
    logic              spk_valid;
    logic              spk_ready = 1'b1;
    logic [4:0]        spk_addr;
    logic              wt_err;
    logic [31:0]       spk_cnt;

    always #5 clk = ~clk;

    conv_nc_fx #(
        .OC_PER_CORE(2), .IN_CHANNELS(2), .KERNEL_SIZE(3), .OUT_W(4), .DW(16), .WW(8),
        .THRESH(64), .LEAK_SHIFT(3), .NEURON_TYPE(0), .RESET_MODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_oc(ev_oc), .ev_ic(ev_ic), .ev_kidx(ev_kidx), .ev_row(ev_row), .ev_col(ev_col),
        .act_start(act_start), .last_ts(last_ts), .act_busy(act_busy), .act_done(act_done),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr),
        .wt_err(wt_err), .spk_cnt(spk_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mem_m [DEPTH];
    int wt_m [NW];
    int cnt_m = 0;
    int exp_q [$];

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767)  return 32767;
        if (x < -32767) return -32767;
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst_n && spk_valid && spk_ready) begin
            if (exp_q.size() == 0) check("spk_unexpected", spk_addr, -1);
            else check("spk_addr", spk_addr, exp_q.pop_front());
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) check($sformatf("%s[%0d]", tag, i), dut.mem_q[i], mem_m[i]);
    endtask

    task automatic do_reset;
        int n = 0;
        rst_n = 1'b0;
        #1;
        check("rst_ev_ready", ev_ready, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_act_busy", act_busy, 0);
        check("rst_act_done", act_done, 0);
        check("rst_spk_cnt", spk_cnt, 0);
        repeat (2) @(posedge clk);
        check("rst_wt_err", wt_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        while (!ev_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("clr_cycles", n, DEPTH);
        step;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = 0;
        exp_q.delete();
        cnt_m = 0;
        cmp_mem("mem_clr");
    endtask

    task automatic wr_wt(input int addr, input int data);
        wt_we = 1'b1;
        wt_addr = 6'(addr);
        wt_wdata = 8'(data);
        step;
        wt_we = 1'b0;
        wt_m[addr] = data;
    endtask

    task automatic send_ev(input int oc, input int ic, input int k, input int row, input int col);
        int n = 0;
        int a;
        ev_valid = 1'b1;
        ev_oc = 2'(oc);
        ev_ic = 2'(ic);
        ev_kidx = 4'(k);
        ev_row = 3'(row);
        ev_col = 3'(col);
        while (!ev_ready && n < 50) begin
            step;
            n++;
        end
        if (!ev_ready) begin
            check("ev_accept_timeout", 0, 1);
        end else if (oc < 2 && ic < 2 && k < 9 && row < 4 && col < 4) begin
            a = oc * 16 + row * 4 + col;
            mem_m[a] = sat(mem_m[a] + wt_m[oc * 19 + ic * 9 + k]);
        end
        step;
    endtask

    task automatic ev_stop;
        ev_valid = 1'b0;
        step;
        step;
    endtask

    task automatic run_act(input bit last, input bit stall, input bit collide, input bit poke, output int cyc);
        int n;
        int hold;
        int v;
        logic [4:0] a0;
        bit busy_seen;
        for (int a = 0; a < DEPTH; a++) begin
            v = sat(mem_m[a] + wt_m[(a / 16) * 19 + 18]);
            if (v > THR) begin
                exp_q.push_back(a);
                cnt_m++;
                v = v - THR;
            end
            v = v - (v >>> 3);
            mem_m[a] = last ? 0 : v;
        end
        last_ts = last;
        if (stall) spk_ready = 1'b0;
        act_start = 1'b1;
        if (collide) begin
            ev_valid = 1'b1;
            ev_oc = '0; ev_ic = '0; ev_kidx = '0; ev_row = '0; ev_col = '0;
            #1;
            check("collide_ready", ev_ready, 0);
        end
        step;
        act_start = 1'b0;
        ev_valid = 1'b0;
        n = 1;
        hold = 0;
        a0 = '0;
        busy_seen = 1'b0;
        while (!act_done && n < 500) begin
            if (act_busy) busy_seen = 1'b1;
            if (poke && n == 3) begin
                wt_we = 1'b1;
                wt_addr = 6'd0;
                wt_wdata = 8'sd99;
            end
            if (poke && n == 4) begin
                wt_we = 1'b0;
                check("wt_err_pulse", wt_err, 1);
            end
            if (poke && n == 5) check("wt_err_clear", wt_err, 0);
            if (stall && spk_valid && !spk_ready) begin
                if (hold == 5) begin
                    spk_ready = 1'b1;
                end else begin
                    if (hold == 0) a0 = spk_addr;
                    else check("stall_addr", spk_addr, a0);
                    hold++;
                end
            end
            step;
            n++;
        end
        check("act_done_seen", act_done, 1);
        cyc = n;
        step;
        check("act_done_pulse", act_done, 0);
        spk_ready = 1'b1;
        last_ts = 1'b0;
        check("busy_seen", busy_seen, 1);
        check("spk_pending", exp_q.size(), 0);
        check("spk_cnt", spk_cnt, cnt_m);
    endtask

    initial begin
        int d0, d1, dx;
        #2;
        do_reset();

        for (int i = 0; i < NW; i++) wr_wt(i, 0);
        wr_wt(0, 40);
        check("wt_err_idle", wt_err, 0);

        send_ev(0, 0, 0, 1, 1);
        send_ev(0, 0, 0, 1, 1);
        ev_stop();
        check("mem5_pair", dut.mem_q[5], 80);
        cmp_mem("mem_pair");

        run_act(0, 0, 0, 0, dx);
        check("mem5_after_act", dut.mem_q[5], 14);
        check("spk_cnt_one", spk_cnt, 1);
        cmp_mem("mem_act1");

        send_ev(0, 0, 0, 1, 1);
        send_ev(0, 0, 0, 1, 1);
        ev_stop();
        run_act(0, 0, 0, 0, d0);
        send_ev(0, 0, 0, 1, 1);
        send_ev(0, 0, 0, 1, 1);
        ev_stop();
        run_act(0, 1, 0, 0, d1);
        check("stall_delta", d1, d0 + 5);
        cmp_mem("mem_stall");

        wr_wt(36, 127);
        for (int i = 0; i < 300; i++) send_ev(1, 1, 8, 2, 3);
        ev_stop();
        check("mem27_sat", dut.mem_q[27], 32767);
        cmp_mem("mem_sat");

        run_act(0, 0, 1, 1, dx);
        cmp_mem("mem_collide");

        send_ev(0, 0, 0, 0, 0);
        ev_stop();
        check("wt0_kept", dut.mem_q[0], 40);
        send_ev(0, 0, 0, 4, 0);
        send_ev(0, 0, 0, 0, 4);
        ev_stop();
        cmp_mem("mem_oob");

        run_act(1, 0, 0, 0, dx);
        cmp_mem("mem_last");

        send_ev(1, 1, 8, 3, 3);
        ev_stop();
        act_start = 1'b1;
        step;
        act_start = 1'b0;
        repeat (5) step;
        check("busy_before_rst", act_busy, 1);
        do_reset();
        send_ev(0, 0, 0, 0, 0);
        ev_stop();
        check("wt_retained", dut.mem_q[0], 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
